// File: rtl/barrett_reduce_pipe.sv
// Pipelined Barrett reducer y = x mod q with on-chip restoring divider for r = floor(2^(2K)/q).
// Optional macro BARRETT_MULIN_EN: operand is in_a*in_b registered in an extra S0 stage.
module barrett_reduce_pipe #(
  parameter int K  = 16,
  parameter int XW = 2*K
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [K-1:0]  cfg_q,
  output logic          cfg_busy,
  output logic          cfg_err,
  output logic          mod_valid,
  input  logic          in_valid,
  output logic          in_ready,
`ifdef BARRETT_MULIN_EN
  input  logic [K-1:0]  in_a,
  input  logic [K-1:0]  in_b,
`else
  input  logic [XW-1:0] in_x,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  out_y
);

  // state | meaning
  // UNCFG | no modulus loaded
  // DIV   | restoring divider computing r
  // RUN   | streaming
  typedef enum logic [1:0] {UNCFG, DIV, RUN} state_t;

  localparam int CW = $clog2(2*K+1);
  localparam int PW = 3*K+1;
  localparam logic [K-1:0] Q_HALF = {1'b1, {(K-1){1'b0}}};

  state_t          state_q, state_d;
  logic [K-1:0]    q_q, q_d;
  logic [K:0]      r_q, r_d;
  logic [K-1:0]    rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic [XW-1:0]   x1_q, x1_d, x2_q, x2_d;
  logic [K:0]      ph1_q, ph1_d;
  logic [XW:0]     m2_q, m2_d;
  logic [K+1:0]    t3_q, t3_d;
  logic [K-1:0]    y4_q, y4_d;

  logic            advance, accept, pipe_busy, cfg_ok;
  logic            s_valid;
  logic [XW-1:0]   s_x;
  logic [K:0]      rem_sh, rem_sub;
  logic            rem_ge;
  logic [K+1:0]    q1_ext, q2_ext, y_full;

  assign advance = !v4_q || out_ready;
  assign in_ready = (state_q == RUN) && advance;
  assign accept = in_valid && in_ready;

`ifdef BARRETT_MULIN_EN
  logic            v0_q, v0_d;
  logic [XW-1:0]   x0_q, x0_d;

  always_comb begin
    v0_d = v0_q;
    x0_d = x0_q;
    if (advance) begin
      v0_d = accept;
      x0_d = {{K{1'b0}}, in_a} * {{K{1'b0}}, in_b};
    end
  end

  assign s_valid = v0_q;
  assign s_x = x0_q;
  assign pipe_busy = v0_q || v1_q || v2_q || v3_q || v4_q;
`else
  assign s_valid = accept;
  assign s_x = in_x;
  assign pipe_busy = v1_q || v2_q || v3_q || v4_q;
`endif

  // A config racing an accepted operand would change q under a live item, so it is rejected.
  assign cfg_ok = (cfg_q > Q_HALF) &&
                  ((state_q == UNCFG) || ((state_q == RUN) && !pipe_busy && !accept));

  assign rem_sh = {rem_q, (cnt_q == CW'(2*K))};
  assign rem_sub = rem_sh - {1'b0, q_q};
  assign rem_ge = (rem_sh >= {1'b0, q_q});

  always_comb begin
    state_d = state_q;
    q_d = q_q;
    r_d = r_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (state_q == DIV) begin
      rem_d = rem_ge ? K'(rem_sub) : K'(rem_sh);
      r_d = {r_q[K-1:0], rem_ge};
      if (cnt_q == '0) state_d = RUN;
      else cnt_d = cnt_q - CW'(1);
    end
    if (cfg_we) begin
      if (cfg_ok) begin
        state_d = DIV;
        q_d = cfg_q;
        r_d = '0;
        rem_d = '0;
        cnt_d = CW'(2*K);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign q1_ext = {2'b00, q_q};
  assign q2_ext = {1'b0, q_q, 1'b0};
  assign y_full = (t3_q >= q2_ext) ? t3_q - q2_ext :
                  (t3_q >= q1_ext) ? t3_q - q1_ext : t3_q;

  always_comb begin
    v1_d = v1_q;  x1_d = x1_q;  ph1_d = ph1_q;
    v2_d = v2_q;  x2_d = x2_q;  m2_d = m2_q;
    v3_d = v3_q;  t3_d = t3_q;
    v4_d = v4_q;  y4_d = y4_q;
    if (advance) begin
      v1_d = s_valid;
      x1_d = s_x;
      ph1_d = (K+1)'(({{(K+1){1'b0}}, s_x} * {{XW{1'b0}}, r_q}) >> (2*K));
      v2_d = v1_q;
      x2_d = x1_q;
      m2_d = {{K{1'b0}}, ph1_q} * {{(K+1){1'b0}}, q_q};
      v3_d = v2_q;
      // x - m is below 3q, so only the low K+2 bits are significant
      t3_d = (K+2)'({1'b0, x2_q} - m2_q);
      v4_d = v3_q;
      y4_d = K'(y_full);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNCFG;
      q_q <= '0;
      r_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      v1_q <= 1'b0;  x1_q <= '0;  ph1_q <= '0;
      v2_q <= 1'b0;  x2_q <= '0;  m2_q <= '0;
      v3_q <= 1'b0;  t3_q <= '0;
      v4_q <= 1'b0;  y4_q <= '0;
`ifdef BARRETT_MULIN_EN
      v0_q <= 1'b0;  x0_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      r_q <= r_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      v1_q <= v1_d;  x1_q <= x1_d;  ph1_q <= ph1_d;
      v2_q <= v2_d;  x2_q <= x2_d;  m2_q <= m2_d;
      v3_q <= v3_d;  t3_q <= t3_d;
      v4_q <= v4_d;  y4_q <= y4_d;
`ifdef BARRETT_MULIN_EN
      v0_q <= v0_d;  x0_q <= x0_d;
`endif
    end
  end

  assign cfg_busy = (state_q == DIV);
  assign mod_valid = (state_q == RUN);
  assign cfg_err = err_q;
  assign out_valid = v4_q;
  assign out_y = y4_q;

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed bench for barrett_reduce_pipe (default build, K=16, 4-cycle latency).
module tb_barrett_reduce_pipe;
  localparam int K = 16;
  localparam int LAT = 4;

  logic          clk, rst_n, cfg_we, in_valid, out_ready;
  logic [K-1:0]  cfg_q;
  logic [2*K-1:0] in_x;
  logic          cfg_busy, cfg_err, mod_valid, in_ready, out_valid;
  logic [K-1:0]  out_y;

  int n_chk = 0;
  int n_fail = 0;
  longint xq[$];
  longint eq[$];

  barrett_reduce_pipe #(.K(K)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_q(cfg_q),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .mod_valid(mod_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(cfg_busy), 0);
    chk({tag, "_err"}, 64'(cfg_err), 0);
    chk({tag, "_modv"}, 64'(mod_valid), 0);
    chk({tag, "_inrdy"}, 64'(in_ready), 0);
    chk({tag, "_outv"}, 64'(out_valid), 0);
    chk({tag, "_y"}, 64'(out_y), 0);
  endtask

  // Applies a config pulse and returns at the negedge where cfg_err reflects it.
  task automatic cfg_pulse(input logic [K-1:0] v);
    cfg_we = 1'b1;
    cfg_q = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100 && cfg_busy; i++) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk({tag, "_arrived"}, 64'(out_valid), 1);
  endtask

  // Streams xq, comparing outputs against eq; out_ready is low for cycles st_lo..st_hi.
  task automatic run_stream(input string tag, input int st_lo, input int st_hi, input bit chk_lat);
    int total, got, bound;
    int accq[$];
    bit prev_stall;
    logic [K-1:0] prev_y;
    total = xq.size();
    got = 0;
    bound = total + 60;
    prev_stall = 1'b0;
    prev_y = '0;
    for (int c = 0; c < bound && got < total; c++) begin
      out_ready = !(c >= st_lo && c <= st_hi);
      in_valid = (xq.size() > 0);
      in_x = in_valid ? 32'(xq[0]) : '0;
      #1;
      if (prev_stall) chk({tag, "_hold"}, 64'(out_y), 64'(prev_y));
      if (out_valid && !out_ready) chk({tag, "_stall_inrdy"}, 64'(in_ready), 0);
      prev_stall = out_valid && !out_ready;
      prev_y = out_y;
      if (in_valid && in_ready) begin
        accq.push_back(c);
        void'(xq.pop_front());
      end
      if (out_valid && out_ready) begin
        if (eq.size() == 0 || accq.size() == 0) begin
          chk({tag, "_extra"}, 1, 0);
        end else begin
          chk({tag, "_y"}, 64'(out_y), 64'(eq.pop_front()));
          if (chk_lat) chk({tag, "_lat"}, 64'(c - accq[0]), LAT);
          void'(accq.pop_front());
        end
        got++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, 64'(got), 64'(total));
    repeat (3) begin
      chk({tag, "_nodup"}, 64'(out_valid), 0);
      @(negedge clk);
    end
    xq.delete();
    eq.delete();
  endtask

  initial begin
    int n;
    logic [31:0] rx;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_q = '0;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    cfg_pulse(16'd32768);
    chk("uncfg_illegal_err", 64'(cfg_err), 1);
    chk("uncfg_illegal_busy", 64'(cfg_busy), 0);
    @(negedge clk);
    chk("uncfg_err_pulse", 64'(cfg_err), 0);
    chk("uncfg_modv", 64'(mod_valid), 0);

    cfg_pulse(16'd65521);
    chk("cfg_ok_err", 64'(cfg_err), 0);
    count_busy(n);
    chk("div_cycles", 64'(n), 33);
    chk("div_modv", 64'(mod_valid), 1);
    chk("div_r", 64'(dut.r_q), 65551);
    chk("run_inrdy", 64'(in_ready), 1);

    xq = '{0, 65521, 64'd4294967295, 64'd4292870400};
    eq = '{0, 0, 224, 1};
    run_stream("s1", 1000, 1000, 1'b1);

    xq = '{0, 65521, 64'd4294967295, 64'd4292870400};
    eq = '{0, 0, 224, 1};
    run_stream("s2stall", 5, 8, 1'b0);

    cfg_pulse(16'd32768);
    chk("run_illegal_err", 64'(cfg_err), 1);
    chk("run_illegal_modv", 64'(mod_valid), 1);

    in_valid = 1'b1;
    in_x = 32'd4294967295;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_pulse(16'd40000);
    chk("inflight_err", 64'(cfg_err), 1);
    chk("inflight_busy", 64'(cfg_busy), 0);
    wait_out("inflight");
    chk("inflight_y", 64'(out_y), 224);
    @(negedge clk);
    chk("keep_q", 64'(dut.q_q), 65521);
    chk("keep_r", 64'(dut.r_q), 65551);
    chk("keep_modv", 64'(mod_valid), 1);

    in_valid = 1'b1;
    in_x = 32'd4292870400;
    cfg_pulse(16'd40961);
    in_valid = 1'b0;
    chk("simul_err", 64'(cfg_err), 1);
    chk("simul_busy", 64'(cfg_busy), 0);
    wait_out("simul");
    chk("simul_y", 64'(out_y), 1);
    @(negedge clk);

    cfg_pulse(16'd40961);
    chk("recfg_busy", 64'(cfg_busy), 1);
    cfg_pulse(16'd50000);
    chk("div_reject_err", 64'(cfg_err), 1);
    chk("div_reject_busy", 64'(cfg_busy), 1);
    count_busy(n);
    chk("recfg_cycles", 64'(n + 1), 33);
    chk("recfg_q", 64'(dut.q_q), 40961);
    chk("recfg_r", 64'(dut.r_q), 104855);

    xq = '{64'd4294967295, 40961, 81923, 40960, 0};
    eq = '{1640, 0, 1, 40960, 0};
    run_stream("q40961", 1000, 1000, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      rx = $urandom;
      xq.push_back(longint'(rx));
      eq.push_back(longint'(rx) % 40961);
    end
    run_stream("rand", 100, 110, 1'b0);

    cfg_pulse(16'd65521);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 64'(cfg_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("rst_div");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_div_uncfg_modv", 64'(mod_valid), 0);
    chk("rst_div_uncfg_inrdy", 64'(in_ready), 0);
    chk("rst_div_uncfg_busy", 64'(cfg_busy), 0);

    cfg_pulse(16'd65521);
    count_busy(n);
    chk("cfg3_modv", 64'(mod_valid), 1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_x = 32'd4294967295;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("stall_outv", 64'(out_valid), 1);
    chk("stall_y", 64'(out_y), 224);
    chk("stall_inrdy", 64'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("rst_stall");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stall_uncfg_modv", 64'(mod_valid), 0);
    chk("rst_stall_uncfg_inrdy", 64'(in_ready), 0);
    chk("rst_stall_outv", 64'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
